// File: rtl/ct_f_spsram_req_ctrl_pkg.sv
// Shared types and constants for the single-port SRAM request controller
// and the SRAM wrappers that sit around it.
package ct_f_spsram_req_ctrl_pkg;

    localparam int DEF_ADDR_WIDTH = 12;
    localparam int DEF_DATA_WIDTH = 84;

    localparam int RSP_DEPTH = 2;
    localparam int RSP_PTR_W = $clog2(RSP_DEPTH);
    localparam int RSP_CNT_W = RSP_PTR_W + 1;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_INIT = 2'd1,
        ST_IDLE = 2'd2
    } state_e;

endpackage

// File: rtl/ct_f_spsram_rsp_fifo.sv
// Small in-order flop FIFO holding SRAM read responses; depth must be a
// power of two so the pointers wrap naturally.
module ct_f_spsram_rsp_fifo
    import ct_f_spsram_req_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_b_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] head_o,
    output logic [RSP_CNT_W-1:0]  cnt_o
);

    logic [DATA_WIDTH-1:0] mem_q [RSP_DEPTH];
    logic [RSP_PTR_W-1:0]  wr_ptr_q;
    logic [RSP_PTR_W-1:0]  rd_ptr_q;
    logic [RSP_CNT_W-1:0]  cnt_q;
    logic                  do_pop;
    logic                  full;

    assign do_pop = pop_i && (cnt_q != '0);
    assign full   = (cnt_q == RSP_CNT_W'(RSP_DEPTH));

    always_ff @(posedge clk_i or negedge rst_b_i) begin
        if (!rst_b_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_i, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign head_o = mem_q[rd_ptr_q];
    assign cnt_o  = cnt_q;

    // Upstream credit accounting must make this unreachable.
    assert property (@(posedge clk_i) disable iff (!rst_b_i) !(push_i && full));

endmodule

// File: rtl/ct_f_spsram_req_ctrl.sv
// Turns a valid/ready request stream into single-port SRAM pin activity,
// zero-fills the array after reset and buffers read data for the consumer.
module ct_f_spsram_req_ctrl
    import ct_f_spsram_req_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter bit INIT_EN    = 1'b1
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH-1:0] req_wmask,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_d,
    output logic [DATA_WIDTH-1:0] sram_wen,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] d_q;
    logic                  rd_inflight_q;
    logic                  init_done_q;
    logic [RSP_CNT_W-1:0]  fifo_cnt;
    logic [RSP_CNT_W:0]    credit_used;
    logic                  xfer;
    logic                  pop;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_BOOT: state_d = INIT_EN ? ST_INIT : ST_IDLE;
            ST_INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pending reads count against buffer space even if a pop is under way,
    // so the ready path never looks at the consumer side.
    assign credit_used = {1'b0, fifo_cnt} + {{RSP_CNT_W{1'b0}}, rd_inflight_q};
    assign req_rdy     = (state_q == ST_IDLE) && (credit_used < (RSP_CNT_W + 1)'(RSP_DEPTH));
    assign xfer        = req_vld && req_rdy;

    always_comb begin
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        sram_a    = a_q;
        sram_d    = d_q;
        if (state_q == ST_INIT) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = '0;
            sram_a    = cnt_q;
            sram_d    = '0;
        end else if (xfer) begin
            sram_cen = 1'b0;
            sram_a   = req_addr;
            if (req_wr) begin
                sram_gwen = 1'b0;
                sram_d    = req_wdata;
                sram_wen  = ~req_wmask;
            end
        end
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q       <= ST_BOOT;
            cnt_q         <= '0;
            a_q           <= '0;
            d_q           <= '0;
            rd_inflight_q <= 1'b0;
            init_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            a_q           <= sram_a;
            d_q           <= sram_d;
            rd_inflight_q <= xfer && !req_wr;
            init_done_q   <= (state_d == ST_IDLE);
        end
    end

    assign init_done = init_done_q;
    assign pop       = rsp_vld && rsp_rdy;
    assign rsp_vld   = (fifo_cnt != '0);

    ct_f_spsram_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rsp_fifo (
        .clk_i   (forever_cpuclk),
        .rst_b_i (cpurst_b),
        .push_i  (rd_inflight_q),
        .data_i  (sram_q),
        .pop_i   (pop),
        .head_o  (rsp_rdata),
        .cnt_o   (fifo_cnt)
    );

endmodule
